// File: rtl/conv_result_reader.sv
// conv_result_reader: streams one convolution result memory out as a
// ready/valid word stream and accumulates a checksum of the words sent.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start, sel_cfg  readback request and memory select (1..5 legal)
//   busy, done, err status: run in progress, end-of-run pulse, bad-select pulse
//   crd, caddr_rd,  memory read strobe, address and select; cdata_rd returns
//   csel, cdata_rd  one cycle after the edge that samples crd
//   odata, ovalid,  output stream; olast marks the final word of the region
//   oready, olast
//   checksum        modulo-2^32 sum of transferred words, held after done
module conv_result_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  sel_cfg,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        crd,
  output logic [11:0] caddr_rd,
  output logic [2:0]  csel,
  input  logic [19:0] cdata_rd,
  output logic [19:0] odata,
  output logic        ovalid,
  input  logic        oready,
  output logic        olast,
  output logic [31:0] checksum
);

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 20;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 32;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t          state, state_nx;
  logic            legal_c, accept_c, pop_c, last_addr_hit_c;
  logic [AW-1:0]   last_addr_c;
  logic [2:0]      used_c;
  logic            pend, pend_last;
  logic [DW-1:0]   t_data;
  logic            t_valid, t_last;

  assign legal_c  = (sel_cfg >= SW'(1)) && (sel_cfg <= SW'(5));
  assign accept_c = (state == IDLE) && start && legal_c;
  assign pop_c    = ovalid & oready;

  // Final address of the region selected by the latched select.
  always_comb begin
    last_addr_c = AW'(2047);
    case (csel)
      SW'(1), SW'(2): last_addr_c = AW'(4095);
      SW'(3), SW'(4): last_addr_c = AW'(1023);
      default:        last_addr_c = AW'(2047);
    endcase
  end

  assign last_addr_hit_c = (caddr_rd == last_addr_c);

  // Slots committed after this cycle: buffered words plus the read in flight,
  // minus the word leaving this cycle. Counting the concurrent pop is what lets
  // a 2-entry buffer sustain one word per cycle across the read latency.
  assign used_c = 3'(ovalid) + 3'(t_valid) + 3'(pend) - 3'(pop_c);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and read strobe.
  always_comb begin
    state_nx = state;
    crd      = 1'b0;
    case (state)
      IDLE:  if (start && legal_c) state_nx = READ;
      READ: begin
        crd = (used_c < 3'd2);
        if (crd && last_addr_hit_c) state_nx = DRAIN;
      end
      DRAIN: if (pop_c && olast) state_nx = FIN;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered status, select latch and read address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      csel      <= '0;
      caddr_rd  <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      busy      <= (state_nx == READ) || (state_nx == DRAIN);
      done      <= (state_nx == FIN);
      err       <= (state == IDLE) && start && !legal_c;
      pend      <= crd;
      pend_last <= crd && last_addr_hit_c;
      if (accept_c)                                     csel <= sel_cfg;
      else if ((state_nx != READ) && (state_nx != DRAIN)) csel <= '0;
      if (accept_c)                       caddr_rd <= '0;
      else if (crd && !last_addr_hit_c)   caddr_rd <= caddr_rd + AW'(1);
    end
  end

  // Two-entry FIFO: the head drives the stream directly, the tail absorbs the
  // word that lands while the head is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      odata   <= '0;
      ovalid  <= 1'b0;
      olast   <= 1'b0;
      t_data  <= '0;
      t_valid <= 1'b0;
      t_last  <= 1'b0;
    end else if (pop_c) begin
      if (t_valid) begin
        odata <= t_data;
        olast <= t_last;
      end else if (pend) begin
        odata <= cdata_rd;
        olast <= pend_last;
      end else begin
        ovalid <= 1'b0;
        olast  <= 1'b0;
      end
      if (t_valid && pend) begin
        t_data <= cdata_rd;
        t_last <= pend_last;
      end else begin
        t_valid <= 1'b0;
      end
    end else if (pend) begin
      if (!ovalid) begin
        odata  <= cdata_rd;
        olast  <= pend_last;
        ovalid <= 1'b1;
      end else begin
        t_data  <= cdata_rd;
        t_last  <= pend_last;
        t_valid <= 1'b1;
      end
    end
  end

  // Checksum of transferred words, restarted by an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        checksum <= '0;
    else if (accept_c) checksum <= '0;
    else if (pop_c)    checksum <= checksum + CW'(odata);
  end

endmodule

// File: tb/tb_conv_result_reader.sv
// Self-checking bench for conv_result_reader: a memory model answers reads,
// a queue-based model holds the words each run must deliver, and a single
// negedge monitor compares the stream, read strobes and status against it.
module tb_conv_result_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  sel_cfg = '0;
  logic        busy, done, err, crd, ovalid, olast;
  logic        oready = 1'b0;
  logic [11:0] caddr_rd;
  logic [2:0]  csel;
  logic [19:0] cdata_rd = '0;
  logic [19:0] odata;
  logic [31:0] checksum;

  conv_result_reader dut (
    .clk(clk), .reset(reset), .start(start), .sel_cfg(sel_cfg),
    .busy(busy), .done(done), .err(err), .crd(crd), .caddr_rd(caddr_rd),
    .csel(csel), .cdata_rd(cdata_rd), .odata(odata), .ovalid(ovalid),
    .oready(oready), .olast(olast), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
  endtask

  // Memory contents: identity for the directed run, hashed otherwise.
  bit          ident_mode = 1'b0;
  logic [31:0] seed = 32'h1234_5678;

  function automatic logic [19:0] mem_word(input int s, input int a);
    logic [31:0] h;
    if (ident_mode) return 20'(a);
    h = 32'(a) * 32'h9E37_79B1;
    h = h ^ (32'(s) << 20) ^ seed;
    return h[31:12];
  endfunction

  function automatic int region_len(input int s);
    if (s == 1 || s == 2) return 4096;
    if (s == 3 || s == 4) return 1024;
    return 2048;
  endfunction

  // Read data valid one edge after the edge that samples crd; junk otherwise.
  always @(posedge clk) begin
    if (crd) cdata_rd <= mem_word(int'(csel), int'(caddr_rd));
    else     cdata_rd <= 20'($urandom);
  end

  // oready pattern: 0 always, 1 toggle, 2 mostly ready, 3 held low, 4 coin flip.
  int rdy_mode = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: oready = 1'b1;
        1: oready = ~oready;
        2: oready = ($urandom_range(0, 3) != 0);
        3: oready = 1'b0;
        default: oready = 1'($urandom);
      endcase
    end
  end

  // Behavioural model of the current run.
  logic [19:0] exp_q[$];
  int          cur_sel = 0, len_m = 0, next_addr = 0, rd_cnt = 0, tx_cnt = 0;
  logic [31:0] sum_m = '0;
  bit          active = 1'b0;
  int          done_cnt = 0, cyc = 0, first_tx_cyc = 0, last_tx_cyc = 0;
  bit          prev_stall = 1'b0;
  logic [19:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    bit pop;
    cyc++;
    if (reset) begin
      pop = ovalid && oready;
      chk("csel", 32'(csel), busy ? 32'(cur_sel) : 32'd0);
      if (crd) begin
        chk("crd_addr", 32'(caddr_rd), 32'(next_addr));
        chk("crd_credit", 32'((rd_cnt - tx_cnt - int'(pop)) < 2), 32'd1);
        chk("crd_range", 32'(active && next_addr < len_m), 32'd1);
        next_addr++;
        rd_cnt++;
      end
      if (prev_stall)
        chk("hold", {11'd0, ovalid, olast, odata}, {11'd0, 1'b1, prev_last, prev_data});
      if (ovalid) chk("ovalid_active", 32'(active), 32'd1);
      if (pop) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'(odata), 32'hFFFF_FFFF);
        end else begin
          chk("odata", 32'(odata), 32'(exp_q[0]));
          chk("olast", 32'(olast), 32'(exp_q.size() == 1));
          sum_m += 32'(exp_q[0]);
          void'(exp_q.pop_front());
          tx_cnt++;
          if (tx_cnt == 1) first_tx_cyc = cyc;
          last_tx_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_empty", 32'(exp_q.size()), 32'd0);
        chk("done_sum", checksum, sum_m);
        active = 1'b0;
      end
      prev_stall = ovalid && !oready;
      prev_data  = odata;
      prev_last  = olast;
    end
  end

  task automatic do_start(input int s);
    @(posedge clk);
    #1;
    if (s >= 1 && s <= 5 && !active) begin
      cur_sel = s;
      len_m   = region_len(s);
      exp_q.delete();
      for (int i = 0; i < len_m; i++) exp_q.push_back(mem_word(s, i));
      sum_m      = '0;
      next_addr  = 0;
      rd_cnt     = 0;
      tx_cnt     = 0;
      prev_stall = 1'b0;
      active     = 1'b1;
    end
    start   = 1'b1;
    sel_cfg = 3'(s);
    @(posedge clk);
    #1;
    start   = 1'b0;
    sel_cfg = 3'($urandom);
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int c = 0;
    while (done_cnt == d0 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk(name, 32'(done_cnt != d0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_tx(input int n, input string name);
    int c = 0;
    while (tx_cnt < n && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk(name, 32'(tx_cnt >= n), 32'd1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctrl"}, 32'({busy, done, err, crd, csel, ovalid, olast}), 32'd0);
    chk({name, "_addr"}, 32'(caddr_rd), 32'd0);
    chk({name, "_odata"}, 32'(odata), 32'd0);
    chk({name, "_sum"}, checksum, 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int d0, c;
    seed = $urandom;
    repeat (2) @(negedge clk);
    chk_all_zero("reset_state");
    #2 reset = 1'b1;

    // Identity memory, full throughput, sel 5.
    ident_mode = 1'b1;
    rdy_mode   = 0;
    repeat (2) @(posedge clk);
    d0 = done_cnt;
    do_start(5);
    @(negedge clk);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_first_rd", 32'({crd, caddr_rd}), 32'h1000);
    chk("s1_lat0", 32'(ovalid), 32'd0);
    @(negedge clk);
    chk("s1_lat1", 32'(ovalid), 32'd0);
    @(negedge clk);
    chk("s1_lat2", 32'({ovalid, odata}), 32'h10_0000);
    wait_done("s1_done");
    chk("s1_checksum", checksum, 32'h001F_FC00);
    chk("s1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("s1_count", 32'(tx_cnt), 32'd2048);
    chk("s1_no_gaps", 32'(last_tx_cyc - first_tx_cyc), 32'd2047);
    chk("s1_idle", 32'({busy, done, crd}), 32'd0);
    ident_mode = 1'b0;

    // Toggling oready, sel 3.
    rdy_mode = 1;
    do_start(3);
    wait_done("s2_done");
    chk("s2_count", 32'(tx_cnt), 32'd1024);
    chk("s2_checksum", checksum, sum_m);

    // Downstream stalled, sel 1.
    rdy_mode = 3;
    do_start(1);
    c = 0;
    while (!ovalid && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("s3_ovalid", 32'(ovalid), 32'd1);
    repeat (50) @(negedge clk);
    chk("s3_reads", 32'(rd_cnt), 32'd2);
    chk("s3_word0", 32'({ovalid, odata}), 32'({1'b1, mem_word(1, 0)}));
    rdy_mode = 0;
    wait_done("s3_done");
    chk("s3_count", 32'(tx_cnt), 32'd4096);

    // Illegal select.
    do_start(6);
    @(negedge clk);
    chk("s4_err", 32'({err, busy, crd}), 32'b100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s4_quiet", 32'({err, busy, crd, ovalid}), 32'd0);
    end

    // Reset mid-run on sel 4, then a fresh run on sel 2.
    rdy_mode = 2;
    do_start(4);
    wait_tx(500, "s5_reach500");
    #2 reset = 1'b0;
    #1;
    chk_all_zero("s5_async");
    active = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("s5_held");
    #2 reset = 1'b1;
    do_start(2);
    @(negedge clk);
    chk("s5_restart", {19'd0, crd, caddr_rd}, 32'h1000);
    chk("s5_sum_clear", checksum, 32'd0);
    rdy_mode = 0;
    wait_done("s5_done");
    chk("s5_count", 32'(tx_cnt), 32'd4096);

    // Second start mid-run must be ignored.
    rdy_mode = 2;
    do_start(5);
    wait_tx(300, "s6_reach300");
    do_start(3);
    wait_done("s6_done");
    chk("s6_count", 32'(tx_cnt), 32'd2048);
    chk("s6_checksum", checksum, sum_m);

    // Random runs.
    for (int r = 0; r < 3; r++) begin
      int s;
      s = int'($urandom_range(1, 5));
      rdy_mode = (r == 1) ? 4 : 2;
      do_start(s);
      wait_done("rnd_done");
      chk("rnd_count", 32'(tx_cnt), 32'(region_len(s)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_result_reader.md
CONV_RESULT_READER -- requirements
Module: conv_result_reader

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset; clears all state immediately when low.
REQ-003 start  in  1  one-cycle request to begin readback of one result memory; sampled only in IDLE.
REQ-004 sel_cfg  in  3  memory select, sampled with start: 1 = L0 kernel0, 2 = L0 kernel1, 3 = L1 kernel0, 4 = L1 kernel1, 5 = L2 flatten.
REQ-005 busy  out  1  high from the cycle after an accepted start until the cycle done is asserted.
REQ-006 done  out  1  one-cycle pulse when the last word has been accepted downstream.
REQ-007 err  out  1  one-cycle pulse when start arrives with sel_cfg of 0, 6 or 7.
REQ-008 crd  out  1  memory read strobe.
REQ-009 caddr_rd  out  12  memory read address.
REQ-010 csel  out  3  memory select; equals latched sel_cfg while busy, else 0.
REQ-011 cdata_rd  in  20  read data, valid on the rising edge one cycle after the edge that sampled crd=1.
REQ-012 odata  out  20  stream data.
REQ-013 ovalid  out  1  stream valid.
REQ-014 oready  in  1  stream ready; a word transfers when ovalid and oready are both high on a rising edge.
REQ-015 olast  out  1  high with the final word of the region.
REQ-016 checksum  out  32  unsigned modulo-2^32 sum of all transferred words, zero-extended; held from done until the next accepted start.

Function
REQ-017 The FSM SHALL have states IDLE, READ, DRAIN and FIN.
- IDLE -> READ on start with a legal sel_cfg.
- READ -> DRAIN after the final address is issued.
- DRAIN -> FIN when the final word transfers.
- FIN -> IDLE after one cycle, with done=1 during FIN.
REQ-018 Region length SHALL be 4096 words for sel 1/2, 1024 for sel 3/4 and 2048 for sel 5; addresses SHALL be issued 0, 1, ... len-1 in order, with no wrap or repeat.
REQ-019 In IDLE, start with an illegal sel_cfg SHALL pulse err the next cycle, stay in IDLE and issue no crd.
REQ-020 start while busy SHALL be ignored, with no effect on the address, sel or checksum.
REQ-021 A 2-entry output buffer SHALL absorb the 1-cycle read latency.
- crd SHALL be asserted only when (buffer occupancy + reads in flight) < 2.
- No word SHALL ever be dropped or duplicated under any oready pattern.
REQ-022 With oready held high, throughput SHALL be one word per cycle; the first ovalid appears 2 cycles after the start edge.
REQ-023 The buffer SHALL be first-in first-out; a simultaneous push and pop SHALL keep occupancy unchanged.
REQ-024 ovalid SHALL remain asserted, and odata/olast stable, until the transfer completes.
REQ-025 olast SHALL be asserted only on word index len-1.
REQ-026 checksum SHALL clear to 0 on an accepted start and add each word at its transfer edge.
REQ-027 crd SHALL be 0 in IDLE, DRAIN and FIN; caddr_rd SHALL hold its last value when crd=0.

Reset
REQ-028 While reset=0, all outputs SHALL be 0, the state SHALL be IDLE and the buffer empty; the effect SHALL be asynchronous.
REQ-029 A reset during READ or DRAIN SHALL abandon the transfer; after release the block SHALL require a new start, and a read in flight at reset SHALL be discarded.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- sel_cfg=5, oready=1, memory word[i]=i -> 2048 words 0..2047 in order; olast on 0x7FF; done once; checksum=0x001FFC00; no gaps after the first word.
- sel_cfg=3, oready toggling 1/0 every cycle -> 1024 words in order; crd never issued when occupancy+inflight=2; checksum matches the model.
- sel_cfg=1, oready=0 for 50 cycles after the first ovalid -> exactly 2 reads issued, then stall; odata holds word 0; all 4096 words complete after release.
- start with sel_cfg=6 -> err pulse 1 cycle later; crd stays 0; busy stays 0.
- reset=0 asserted at word 500 of sel 4 -> all outputs 0 immediately; after release a new start on sel 2 begins at address 0 with checksum restarted.
- second start mid-run on sel 5 -> ignored; the stream continues unchanged.
